complex_divider: RTL and testbench
==================================

COMPLEX_DIVIDER -- requirements
Module: complex_divider

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the signed two's-complement width of every complex component in and out.
REQ-002 Parameter FRAC_BITS, default 8, SHALL set the fractional bits of the fixed-point format shared by inputs and outputs.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  in  1  SHALL mean the upstream evaluator presents a valid operand set.
REQ-006 in_ready  out  1  SHALL mean the block accepts operands this cycle.
REQ-007 num_re, num_im  in  DATA_WIDTH  SHALL be the numerator real and imaginary parts.
REQ-008 den_re, den_im  in  DATA_WIDTH  SHALL be the denominator real and imaginary parts.
REQ-009 out_valid  out  1  SHALL mean the quotient outputs are valid.
REQ-010 out_ready  in  1  SHALL mean downstream consumes the result this cycle.
REQ-011 q_re, q_im  out  DATA_WIDTH  SHALL be the quotient real and imaginary parts.
REQ-012 div_by_zero  out  1  SHALL flag a result produced from a zero denominator; valid with out_valid.

Function
REQ-013 The block SHALL compute q = N/D as (N*conj(D))/|D|^2: P_re = Nr*Dr + Ni*Di; P_im = Ni*Dr - Nr*Di; M = Dr^2 + Di^2.
REQ-014 P_re and P_im SHALL be held at 2*DATA_WIDTH+1 signed bits and M at 2*DATA_WIDTH+1 unsigned bits, with no intermediate truncation.
REQ-015 Each quotient SHALL equal sign(P) * floor((|P| << FRAC_BITS) / M), truncating toward zero.
REQ-016 Any quotient magnitude above 2^(DATA_WIDTH-1)-1 SHALL saturate to +/-(2^(DATA_WIDTH-1)-1); the most negative code is never produced.
REQ-017 States SHALL be IDLE, PREP, DIV and DONE.
REQ-018 IDLE: in_ready=1; on in_valid&&in_ready, operands are registered and the state moves to PREP.
REQ-019 PREP (1 cycle): form P, M, the signs and the saturation flags; if M==0 go to DONE, else to DIV.
REQ-020 DIV: restoring division, one quotient bit per cycle for the real and imaginary parts in parallel, DATA_WIDTH-1 cycles, MSB first; then go to DONE.
REQ-021 DONE: out_valid=1, and outputs are held stable until out_valid&&out_ready; on that handshake go to IDLE.
REQ-022 Latency SHALL be exactly DATA_WIDTH cycles from the accept edge to out_valid when out_ready is already high; for a zero denominator it SHALL be 2 cycles.
REQ-023 in_ready SHALL be 0 in PREP, DIV and DONE (one operation outstanding); throughput is at most one result per DATA_WIDTH+1 cycles.
REQ-024 M==0 SHALL produce q_re=q_im=0 with div_by_zero=1; otherwise div_by_zero SHALL be 0.
REQ-025 A zero numerator with nonzero M SHALL give 0,0 and div_by_zero=0.
REQ-026 Inputs SHALL be ignored outside the accept handshake, and out_ready SHALL be ignored outside DONE.

Reset
REQ-027 While rst_n is low: state=IDLE, out_valid=0, q_re=q_im=0, div_by_zero=0, in_ready=1; internal registers are cleared.
REQ-028 Reset asserted mid-operation (PREP, DIV or DONE) SHALL abandon the operation with no result emitted; the first accept is possible on the first edge after release.

Structure
REQ-029 Shared package hayes_pkg SHALL hold DATA_WIDTH, FRAC_BITS, the state enumeration and the derived widths (product, magnitude, dividend).
REQ-030 A single sub-module, udiv_iter (an unsigned restoring-division iterator with start, done and saturate handling), SHALL be instantiated twice, once for the real part and once for the imaginary part.

Verification
REQ-031 The bench (DATA_WIDTH=16, FRAC_BITS=8) SHALL cover the following directed scenarios:
- Real divide: N=(0x0200,0), D=(0x0100,0) -> q=(0x0200,0x0000), div_by_zero=0, out_valid 16 cycles after accept.
- Complex divide: N=(0x0100,0x0100), D=(0x0000,0x0100) -> q=(0x0100,0xFF00).
- Truncation: N=(0x0100,0), D=(0x0300,0) -> q_re=0x0055; N=(0xFF00,0), D=(0x0300,0) -> q_re=0xFFAB.
- Saturation and zero divisor: N=(0x7FFF,0x8001), D=(0x0001,0) -> q=(0x7FFF,0x8001); D=(0,0) -> q=(0,0), div_by_zero=1, out_valid 2 cycles after accept.
- Backpressure: out_ready held low for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; in_ready rises the cycle after the handshake.
- Reset mid-DIV: rst_n pulsed low in DIV -> out_valid never rises for that operation; the next operation returns the correct result.

Source files
------------

// File: rtl/hayes_pkg.sv
// Shared constants, derived widths and FSM state encoding for the complex divider.
package hayes_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;

    function automatic int prod_w(input int dw);
        return 2 * dw + 1;
    endfunction

    function automatic int mag_w(input int dw);
        return 2 * dw + 1;
    endfunction

    function automatic int dvd_w(input int dw, input int fb);
        return 2 * dw + 1 + fb;
    endfunction

    localparam int PROD_W = prod_w(DATA_WIDTH);
    localparam int MAG_W  = mag_w(DATA_WIDTH);
    localparam int DVD_W  = dvd_w(DATA_WIDTH, FRAC_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_DIV,
        ST_DONE
    } state_t;

endpackage

// File: rtl/complex_divider_udiv_iter.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, with a saturate override.
module udiv_iter #(
    parameter int QUO_W      = hayes_pkg::DATA_WIDTH - 1,
    parameter int DIVIDEND_W = hayes_pkg::DVD_W,
    parameter int DIVISOR_W  = hayes_pkg::MAG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  saturate,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  done,
    output logic [QUO_W-1:0]      quotient
);

    localparam int REM_W = DIVISOR_W + QUO_W;
    localparam int CNT_W = $clog2(QUO_W + 1);

    logic [REM_W-1:0] rem, dsr;
    logic [REM_W-1:0] rem_in, dsr_in, diff;
    logic [QUO_W-1:0] quo;
    logic [CNT_W-1:0] cnt;
    logic             busy, sat, qbit;

    // The start cycle already resolves the MSB against the freshly formed operands.
    always_comb begin
        rem_in = start ? REM_W'(dividend) : rem;
        dsr_in = start ? (REM_W'(divisor) << (QUO_W - 1)) : dsr;
        diff   = rem_in - dsr_in;
        qbit   = (rem_in >= dsr_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            dsr  <= '0;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            sat  <= 1'b0;
        end else if (start) begin
            if (divisor == '0) begin
                rem  <= '0;
                dsr  <= '0;
                quo  <= '0;
                cnt  <= '0;
                busy <= 1'b0;
                sat  <= 1'b0;
            end else begin
                rem  <= qbit ? diff : rem_in;
                dsr  <= dsr_in >> 1;
                quo  <= {{(QUO_W-1){1'b0}}, qbit};
                cnt  <= CNT_W'(QUO_W - 1);
                busy <= 1'b1;
                sat  <= saturate;
            end
        end else if (busy) begin
            rem <= qbit ? diff : rem;
            dsr <= dsr >> 1;
            quo <= {quo[QUO_W-2:0], qbit};
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    // done marks the cycle whose closing edge writes the final quotient bit
    assign done     = busy && (cnt == CNT_W'(1));
    assign quotient = sat ? '1 : quo;

endmodule

// File: rtl/complex_divider.sv
// Fixed-point complex divider q = N*conj(D)/|D|^2 with valid/ready handshakes.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | in_ready=1, waiting for an operand set
//   PREP    | form P, M, signs, saturation; first quotient bit resolved
//   DIV     | remaining quotient bits, both components in lockstep
//   DONE    | out_valid=1, result held until out_ready
module complex_divider #(
    parameter int DATA_WIDTH = hayes_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = hayes_pkg::FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] num_re,
    input  logic [DATA_WIDTH-1:0] num_im,
    input  logic [DATA_WIDTH-1:0] den_re,
    input  logic [DATA_WIDTH-1:0] den_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] q_re,
    output logic [DATA_WIDTH-1:0] q_im,
    output logic                  div_by_zero
);
    import hayes_pkg::*;

    localparam int PW = prod_w(DATA_WIDTH);
    localparam int MW = mag_w(DATA_WIDTH);
    localparam int VW = dvd_w(DATA_WIDTH, FRAC_BITS);
    localparam int QW = DATA_WIDTH - 1;
    localparam int CW = MW + QW;

    state_t state, state_nx;

    logic signed [DATA_WIDTH-1:0] nr, ni, dr, di;
    logic signed [PW-1:0]         nr_x, ni_x, dr_x, di_x;
    logic signed [PW-1:0]         p_re, p_im;
    logic [MW-1:0]                m;
    logic [PW-1:0]                abs_re, abs_im;
    logic [VW-1:0]                dvd_re, dvd_im;
    logic                         sat_re, sat_im, m_zero, start;
    logic                         neg_re, neg_im, dbz;
    logic                         done_re, done_im;
    logic [QW-1:0]                mag_re, mag_im;
    logic [DATA_WIDTH-1:0]        ext_re, ext_im;

    always_comb begin
        nr_x   = PW'(nr);
        ni_x   = PW'(ni);
        dr_x   = PW'(dr);
        di_x   = PW'(di);
        p_re   = nr_x * dr_x + ni_x * di_x;
        p_im   = ni_x * dr_x - nr_x * di_x;
        m      = dr_x * dr_x + di_x * di_x;
        abs_re = p_re[PW-1] ? $unsigned(-p_re) : $unsigned(p_re);
        abs_im = p_im[PW-1] ? $unsigned(-p_im) : $unsigned(p_im);
        dvd_re = {abs_re, {FRAC_BITS{1'b0}}};
        dvd_im = {abs_im, {FRAC_BITS{1'b0}}};
        m_zero = (m == '0);
        // quotient needs more than QW bits exactly when dividend >= M * 2^QW
        sat_re = !m_zero && ({{(CW-VW){1'b0}}, dvd_re} >= {m, {QW{1'b0}}});
        sat_im = !m_zero && ({{(CW-VW){1'b0}}, dvd_im} >= {m, {QW{1'b0}}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ST_PREP;
            end
            ST_PREP: begin
                start    = 1'b1;
                state_nx = m_zero ? ST_DONE : ST_DIV;
            end
            ST_DIV: begin
                if (done_re && done_im) state_nx = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nr     <= '0;
            ni     <= '0;
            dr     <= '0;
            di     <= '0;
            neg_re <= 1'b0;
            neg_im <= 1'b0;
            dbz    <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            nr  <= num_re;
            ni  <= num_im;
            dr  <= den_re;
            di  <= den_im;
            dbz <= 1'b0;
        end else if (start) begin
            neg_re <= p_re[PW-1] && !m_zero;
            neg_im <= p_im[PW-1] && !m_zero;
            dbz    <= m_zero;
        end
    end

    udiv_iter #(.QUO_W(QW), .DIVIDEND_W(VW), .DIVISOR_W(MW)) u_div_re (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .saturate (sat_re),
        .dividend (dvd_re),
        .divisor  (m),
        .done     (done_re),
        .quotient (mag_re)
    );

    udiv_iter #(.QUO_W(QW), .DIVIDEND_W(VW), .DIVISOR_W(MW)) u_div_im (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .saturate (sat_im),
        .dividend (dvd_im),
        .divisor  (m),
        .done     (done_im),
        .quotient (mag_im)
    );

    // magnitudes never exceed 2^(W-1)-1, so negation cannot reach the most negative code
    always_comb begin
        ext_re = {1'b0, mag_re};
        ext_im = {1'b0, mag_im};
        q_re   = neg_re ? -ext_re : ext_re;
        q_im   = neg_im ? -ext_im : ext_im;
    end

    assign div_by_zero = dbz;

endmodule

// File: tb/tb_complex_divider.sv
// Self-checking bench for complex_divider: vector table, random model vectors, corner sequences.
module tb_complex_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, div_by_zero;
    logic [15:0] num_re = '0, num_im = '0, den_re = '0, den_im = '0;
    logic [15:0] q_re, q_im;

    always #5 clk = ~clk;

    complex_divider #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .num_re      (num_re),
        .num_im      (num_im),
        .den_re      (den_re),
        .den_im      (den_im),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q_re        (q_re),
        .q_im        (q_im),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [15:0] nr, ni, dr, di;
        logic [15:0] er, ei;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [15:0] er, ei;
        logic        dbz;
    } want_t;

    want_t sb_q[$];
    vec_t  tbl[10];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Reference: truncating signed division of P*2^8 by M, clamped to +/-32767.
    function automatic vec_t model(input logic [15:0] nr, ni, dr, di);
        vec_t   r;
        longint a, b, c, d, pre, pim, m, qr, qi;
        a = longint'($signed(nr));
        b = longint'($signed(ni));
        c = longint'($signed(dr));
        d = longint'($signed(di));
        pre = a * c + b * d;
        pim = b * c - a * d;
        m   = c * c + d * d;
        r.nr = nr; r.ni = ni; r.dr = dr; r.di = di;
        if (m == 0) begin
            r.er = '0; r.ei = '0; r.dbz = 1'b1;
        end else begin
            qr = (pre * 256) / m;
            qi = (pim * 256) / m;
            if (qr > 32767)  qr = 32767;
            if (qr < -32767) qr = -32767;
            if (qi > 32767)  qi = 32767;
            if (qi < -32767) qi = -32767;
            r.er = 16'(qr); r.ei = 16'(qi); r.dbz = 1'b0;
        end
        return r;
    endfunction

    // Latency counts the accept cycle as cycle 1.
    task automatic run_op(input vec_t v, input int hold, input string tag);
        int    n;
        int    lat;
        want_t w;
        out_ready = (hold == 0);
        num_re = v.nr; num_im = v.ni; den_re = v.dr; den_im = v.di;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " accept_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        num_re = 16'($urandom); num_im = 16'($urandom);
        den_re = 16'($urandom); den_im = 16'($urandom);
        sb_q.push_back('{v.er, v.ei, v.dbz});
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, " latency"}, 32'(lat), (v.dr == 0 && v.di == 0) ? 32'd2 : 32'd16);
        w = sb_q.pop_front();
        check({tag, " q_re"}, 32'(q_re), 32'(w.er));
        check({tag, " q_im"}, 32'(q_im), 32'(w.ei));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(w.dbz));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " stall q_re"}, 32'(q_re), 32'(w.er));
            check({tag, " stall q_im"}, 32'(q_im), 32'(w.ei));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        vec_t v;

        tbl[0] = '{16'h0200, 16'h0000, 16'h0100, 16'h0000, 16'h0200, 16'h0000, 1'b0};
        tbl[1] = '{16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'hFF00, 1'b0};
        tbl[2] = '{16'h0100, 16'h0000, 16'h0300, 16'h0000, 16'h0055, 16'h0000, 1'b0};
        tbl[3] = '{16'hFF00, 16'h0000, 16'h0300, 16'h0000, 16'hFFAB, 16'h0000, 1'b0};
        tbl[4] = '{16'h7FFF, 16'h8001, 16'h0001, 16'h0000, 16'h7FFF, 16'h8001, 1'b0};
        tbl[5] = '{16'h7FFF, 16'h8001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        tbl[6] = '{16'h0000, 16'h0000, 16'h0100, 16'h0200, 16'h0000, 16'h0000, 1'b0};
        tbl[7] = '{16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0100, 16'h0000, 1'b0};
        tbl[8] = '{16'h8000, 16'h0000, 16'h0001, 16'h0000, 16'h8001, 16'h0000, 1'b0};
        tbl[9] = '{16'h0100, 16'h0000, 16'h0000, 16'hFF00, 16'h0000, 16'h0100, 1'b0};

        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset q_re", 32'(q_re), 32'd0);
        check("reset q_im", 32'(q_im), 32'd0);
        check("reset div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i], 0, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            v = model(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            run_op(v, 0, $sformatf("rand%0d", i));
        end

        run_op(tbl[1], 5, "backpressure");

        // abandon an operation mid-DIV
        num_re = tbl[0].nr; num_im = tbl[0].ni; den_re = tbl[0].dr; den_im = tbl[0].di;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid-div in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #2;
        check("mid-div reset in_ready", 32'(in_ready), 32'd1);
        check("mid-div reset out_valid", 32'(out_valid), 32'd0);
        check("mid-div reset q_re", 32'(q_re), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abandoned op out_valid count", 32'(seen), 32'd0);
        run_op(tbl[3], 0, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
